// File: rtl/fm_lfo.sv
// FM synthesis LFO: tremolo triangle (am_val) and vibrato F-number offset (fnum_out).
// Vibrato logic is present only when FM_LFO_VIB_EN is defined; otherwise fnum_out passes fnum_in.
module fm_lfo (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       dam,
    input  logic       dvb,
    input  logic       vib,
    input  logic [9:0] fnum_in,
    output logic [5:0] am_val,
    output logic [2:0] vib_pos,
    output logic [9:0] fnum_out
);

    logic [5:0] trem_div;
    logic [7:0] trem_pos;
    logic [6:0] am_raw;

    // Triangle: rises 0..104 over positions 0..104, then mirrors back down to 0 at 209.
    always_comb begin
        am_raw = '0;
        if (trem_pos < 8'd105) begin
            am_raw = trem_pos[6:0];
        end else begin
            am_raw = 7'(8'd209 - trem_pos);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trem_div <= '0;
            trem_pos <= '0;
            am_val   <= '0;
        end else begin
            am_val <= dam ? {1'b0, am_raw[6:2]} : {3'b000, am_raw[6:4]};
            if (sample_tick) begin
                trem_div <= trem_div + 6'd1;
                if (trem_div == 6'd63) begin
                    trem_pos <= (trem_pos == 8'd209) ? '0 : trem_pos + 8'd1;
                end
            end
        end
    end

`ifdef FM_LFO_VIB_EN
    logic [9:0] vib_div;
    logic [2:0] vib_base;
    logic [2:0] vib_mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            vib_div <= '0;
            vib_pos <= '0;
        end else if (sample_tick) begin
            vib_div <= vib_div + 10'd1;
            if (vib_div == 10'h3FF) begin
                vib_pos <= vib_pos + 3'd1;
            end
        end
    end

    // Magnitude depends on vib_pos[1:0]; vib_pos[2] selects subtraction for the falling half.
    always_comb begin
        vib_base = dvb ? fnum_in[9:7] : {1'b0, fnum_in[9:8]};
        vib_mag  = '0;
        case (vib_pos[1:0])
            2'd0:    vib_mag = '0;
            2'd2:    vib_mag = vib_base;
            default: vib_mag = {1'b0, vib_base[2:1]};
        endcase
        fnum_out = fnum_in;
        if (vib) begin
            fnum_out = vib_pos[2] ? fnum_in - {7'd0, vib_mag} : fnum_in + {7'd0, vib_mag};
        end
    end
`else
    logic unused_vib_inputs;

    assign unused_vib_inputs = ^{vib, dvb};
    assign vib_pos           = '0;
    assign fnum_out          = fnum_in;
`endif

endmodule

// File: tb/tb_fm_lfo.sv
// Directed table-driven bench for fm_lfo; vibrato vectors are selected by FM_LFO_VIB_EN.
module tb_fm_lfo;

    logic       clk;
    logic       reset;
    logic       sample_tick;
    logic       dam;
    logic       dvb;
    logic       vib;
    logic [9:0] fnum_in;
    logic [5:0] am_val;
    logic [2:0] vib_pos;
    logic [9:0] fnum_out;

    int checks;
    int failures;

    fm_lfo dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .dam         (dam),
        .dvb         (dvb),
        .vib         (vib),
        .fnum_in     (fnum_in),
        .am_val      (am_val),
        .vib_pos     (vib_pos),
        .fnum_out    (fnum_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         ticks;
        logic       dam;
        logic [5:0] exp_am;
    } trem_vec_t;

    typedef struct {
        int         ticks;
        logic       vib;
        logic       dvb;
        logic [9:0] fnum;
        logic [2:0] exp_pos;
        logic [9:0] exp_fnum;
    } vib_vec_t;

    trem_vec_t tv[14];
    vib_vec_t  vv[14];

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    // n back-to-back ticks, then one idle edge so am_val reflects the final trem_pos.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sample_tick = 1'b1;
        end
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        sample_tick = 1'b1;
        repeat (2) @(negedge clk);
        reset       = 1'b0;
        sample_tick = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        sample_tick = 1'b0;
        dam         = 1'b1;
        dvb         = 1'b1;
        vib         = 1'b1;
        fnum_in     = 10'h3FF;

        // Cumulative from reset; comment gives the resulting trem_pos.
        tv[0]  = '{64,   1'b1, 6'd0};   // 1
        tv[1]  = '{192,  1'b1, 6'd1};   // 4
        tv[2]  = '{6400, 1'b1, 6'd26};  // 104
        tv[3]  = '{64,   1'b1, 6'd26};  // 105 (6720 ticks)
        tv[4]  = '{0,    1'b0, 6'd6};   // dam change alone
        tv[5]  = '{64,   1'b0, 6'd6};   // 106, raw 103
        tv[6]  = '{0,    1'b1, 6'd25};
        tv[7]  = '{6016, 1'b1, 6'd2};   // 200, raw 9
        tv[8]  = '{576,  1'b1, 6'd0};   // 209, raw 0
        tv[9]  = '{64,   1'b1, 6'd0};   // 0 (13440 ticks)
        tv[10] = '{512,  1'b1, 6'd2};   // 8
        tv[11] = '{255,  1'b1, 6'd2};   // 11, divider at 63
        tv[12] = '{1,    1'b1, 6'd3};   // 12
        tv[13] = '{0,    1'b0, 6'd0};

        // Cumulative from reset, dam=1 throughout.
        vv[0]  = '{0,    1'b1, 1'b1, 10'h3FF, 3'd0, 10'h3FF};
        vv[1]  = '{1023, 1'b1, 1'b1, 10'h380, 3'd0, 10'h380};
        vv[2]  = '{1,    1'b1, 1'b1, 10'h3FF, 3'd1, 10'h002};
        vv[3]  = '{1024, 1'b1, 1'b1, 10'h3FF, 3'd2, 10'h006};
        vv[4]  = '{0,    1'b0, 1'b1, 10'h3FF, 3'd2, 10'h3FF};
        vv[5]  = '{0,    1'b1, 1'b0, 10'h3FF, 3'd2, 10'h002};
        vv[6]  = '{1024, 1'b1, 1'b1, 10'h100, 3'd3, 10'h101};
        vv[7]  = '{1024, 1'b1, 1'b1, 10'h3FF, 3'd4, 10'h3FF};
        vv[8]  = '{1024, 1'b1, 1'b1, 10'h3FF, 3'd5, 10'h3FC};
        vv[9]  = '{1024, 1'b1, 1'b0, 10'h200, 3'd6, 10'h1FE};
        vv[10] = '{0,    1'b0, 1'b0, 10'h200, 3'd6, 10'h200};
        vv[11] = '{0,    1'b1, 1'b1, 10'h080, 3'd6, 10'h07F};
        vv[12] = '{1024, 1'b1, 1'b1, 10'h300, 3'd7, 10'h2FD};
        vv[13] = '{1024, 1'b1, 1'b1, 10'h3FF, 3'd0, 10'h3FF};

        do_reset();
        check("reset_am_val", 0, 32'(am_val), 32'd0);
        check("reset_vib_pos", 0, 32'(vib_pos), 32'd0);
        check("reset_fnum_out", 0, 32'(fnum_out), 32'h3FF);

        for (int i = 0; i < 14; i++) begin
            dam = tv[i].dam;
            run_ticks(tv[i].ticks);
            check("trem_vec", i, 32'(am_val), 32'(tv[i].exp_am));
        end

        // No ticks for 300 cycles: a free-running counter would reach trem_pos 16 (am 4).
        dam = 1'b1;
        repeat (300) @(negedge clk);
        check("hold_no_tick", 0, 32'(am_val), 32'd3);

        // Reset mid-period with the divider part-way (trem_pos 50, divider 30).
        do_reset();
        run_ticks(3230);
        check("pre_reset_am", 0, 32'(am_val), 32'd12);
        @(negedge clk);
        reset       = 1'b1;
        sample_tick = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        sample_tick = 1'b0;
        check("mid_reset_am", 0, 32'(am_val), 32'd0);
        run_ticks(255);
        check("post_reset_restart", 0, 32'(am_val), 32'd0);
        run_ticks(1);
        check("post_reset_restart", 1, 32'(am_val), 32'd1);

        do_reset();
        dam = 1'b1;
`ifdef FM_LFO_VIB_EN
        for (int i = 0; i < 14; i++) begin
            run_ticks(vv[i].ticks);
            vib     = vv[i].vib;
            dvb     = vv[i].dvb;
            fnum_in = vv[i].fnum;
            #1;
            check("vib_pos_vec", i, 32'(vib_pos), 32'(vv[i].exp_pos));
            check("fnum_out_vec", i, 32'(fnum_out), 32'(vv[i].exp_fnum));
            // 1024 ticks: trem_pos 16 advanced on the same tick as vib_pos.
            if (i == 2) check("joint_wrap_am", 0, 32'(am_val), 32'd4);
        end
`else
        vib     = 1'b1;
        dvb     = 1'b1;
        fnum_in = 10'h3FF;
        run_ticks(5000);
        #1;
        check("novib_vib_pos", 0, 32'(vib_pos), 32'd0);
        check("novib_fnum_out", 0, 32'(fnum_out), 32'h3FF);
        check("novib_am", 0, 32'(am_val), 32'd19);
        fnum_in = 10'h200;
        dvb     = 1'b0;
        #1;
        check("novib_fnum_out", 1, 32'(fnum_out), 32'h200);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
